// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// risc_pkg : shared widths and the write-back queue entry type. Rev 1.0
// ============================================================================
package risc_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : DEPTH-entry write-back queue exposing its storage for bypass. Rev 1.0
// ============================================================================
module wb_fifo
  import risc_pkg::wb_entry_t;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output wb_entry_t                entries_o [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head_o,
  output logic [$clog2(DEPTH)-1:0] tail_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  wb_entry_t            mem_q [DEPTH];
  logic [C_PTR_W-1:0]   head_q, head_d;
  logic [C_PTR_W-1:0]   tail_q, tail_d;
  logic [C_CNT_W-1:0]   count_q, count_d;

  // Pointers are exactly log2(DEPTH) wide, so wrap-around is free.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + C_PTR_W'(1);
    if (pop_i)  head_d = head_q + C_PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + C_CNT_W'(1);
      2'b01:   count_d = count_q - C_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// writeback_unit : arbitrates ALU/load results into the register-file write port with bypass. Rev 1.0
// ============================================================================
module writeback_unit
  import risc_pkg::wb_entry_t;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = risc_pkg::XLEN,
  parameter int AW    = risc_pkg::REG_AW
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  input  logic                   wb_stall,
  output logic                   wb_we,
  output logic [AW-1:0]          wb_addr,
  output logic [XLEN-1:0]        wb_data,
  input  logic [AW-1:0]          query_addr,
  output logic                   query_hit,
  output logic [XLEN-1:0]        query_data,
  output logic [$clog2(DEPTH):0] pending_cnt
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  logic               w_base_ready;
  logic               w_grant_alu, w_grant_mem;
  logic               w_alu_acc, w_mem_acc, w_accept;
  logic               w_push, w_pop;
  wb_entry_t          w_push_entry, w_head_entry;
  wb_entry_t          w_entries [DEPTH];
  logic [C_PTR_W-1:0] w_head, w_tail;
  logic [C_CNT_W-1:0] w_count;

  logic               rr_alu_first_q, rr_alu_first_d;
  logic               wb_we_q, wb_we_d;
  logic [AW-1:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;

  // Readiness looks only at the registered count, never at a same-cycle pop.
  assign w_base_ready = (w_count < C_CNT_W'(DEPTH));
  assign w_grant_alu  = alu_valid & (~mem_valid | rr_alu_first_q);
  assign w_grant_mem  = mem_valid & (~alu_valid | ~rr_alu_first_q);
  assign alu_ready    = w_base_ready & w_grant_alu;
  assign mem_ready    = w_base_ready & w_grant_mem;
  assign w_alu_acc    = alu_valid & alu_ready;
  assign w_mem_acc    = mem_valid & mem_ready;
  assign w_accept     = w_alu_acc | w_mem_acc;

  assign w_push_entry.rd   = w_grant_alu ? alu_rd : mem_rd;
  assign w_push_entry.data = w_grant_alu ? alu_data : mem_data;
  assign w_push            = w_accept & (w_push_entry.rd != '0);
  assign w_pop             = (w_count != '0) & ~wb_stall;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .entries_o    (w_entries),
    .head_o       (w_head),
    .tail_o       (w_tail),
    .count_o      (w_count)
  );

  assign w_head_entry = w_entries[w_head];

  always_comb begin
    rr_alu_first_d = rr_alu_first_q;
    if (alu_valid && mem_valid && w_accept) rr_alu_first_d = ~rr_alu_first_q;
  end

  always_comb begin
    wb_we_d   = wb_we_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (!wb_stall) begin
      if (w_count != '0) begin
        wb_we_d   = 1'b1;
        wb_addr_d = w_head_entry.rd;
        wb_data_d = w_head_entry.data;
      end else begin
        wb_we_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_alu_first_q <= 1'b1;
      wb_we_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
    end else begin
      rr_alu_first_q <= rr_alu_first_d;
      wb_we_q        <= wb_we_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign wb_we       = wb_we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign pending_cnt = w_count;

  // Lowest priority first so the newest queued match is the last one written.
  always_comb begin
    logic [C_PTR_W-1:0] idx;
    idx        = '0;
    query_hit  = 1'b0;
    query_data = '0;
    if (wb_we_q && (wb_addr_q == query_addr)) begin
      query_hit  = 1'b1;
      query_data = wb_data_q;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = w_tail - C_PTR_W'(i + 1);
      if ((C_CNT_W'(i) < w_count) && (w_entries[idx].rd == query_addr)) begin
        query_hit  = 1'b1;
        query_data = w_entries[idx].data;
      end
    end
    if (query_addr == '0) begin
      query_hit  = 1'b0;
      query_data = '0;
    end
  end

endmodule
`default_nettype wire
